// File: rtl/exe_div_unit_pkg.sv
// Shared CPU package slice for the EXE-stage divider: divider width, FSM
// encoding, divide-by-zero result constants and sign-handling helpers.
package exe_div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 5;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = DIV_CNT_W'(DIV_WIDTH - 1);

    // Divide-by-zero: all-ones quotient; remainder is the raw dividend
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] div_mag(
        input logic [DIV_WIDTH-1:0] v,
        input logic                 sgn
    );
        return (sgn && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] div_cond_neg(
        input logic [DIV_WIDTH-1:0] v,
        input logic                 neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/exe_div_unit.sv
// Multi-cycle restoring radix-2 divider for the EXE stage (DIV/DIVU -> LO/HI).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module exe_div_unit
    import exe_div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_sign,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 flush,
    output logic                 div_stall,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    div_state_e state, state_next;

    logic [DIV_WIDTH-1:0] quo_sr;
    logic [DIV_WIDTH-1:0] rem_acc;
    logic [DIV_WIDTH-1:0] dvsr;
    logic                 neg_q;
    logic                 neg_r;
    logic [DIV_CNT_W-1:0] cnt;

    logic [DIV_WIDTH-1:0] a_mag;
    logic [DIV_WIDTH-1:0] b_mag;
    logic                 div_zero;
    logic                 early;

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH:0]   diff;
    logic                 fits;
    logic [DIV_WIDTH-1:0] rem_step;
    logic [DIV_WIDTH-1:0] quo_step;

    logic                 accept;
    logic                 res_we;
    logic [DIV_WIDTH-1:0] res_q;
    logic [DIV_WIDTH-1:0] res_r;

    always_comb begin
        a_mag    = div_mag(dividend, is_sign);
        b_mag    = div_mag(divisor, is_sign);
        div_zero = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
        early    = !div_zero && (a_mag < b_mag);
`else
        early    = 1'b0;
`endif
    end

    // Borrow out of the 33-bit trial subtraction means the divisor did not fit
    always_comb begin
        shifted  = {rem_acc, quo_sr[DIV_WIDTH-1]};
        diff     = shifted - {1'b0, dvsr};
        fits     = !diff[DIV_WIDTH];
        rem_step = fits ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
        quo_step = {quo_sr[DIV_WIDTH-2:0], fits};
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        res_we     = 1'b0;
        res_q      = '0;
        res_r      = '0;
        div_stall  = 1'b0;
        done       = 1'b0;

        case (state)
            DIV_IDLE: begin
                if (start && !flush) begin
                    div_stall = 1'b1;
                    accept    = 1'b1;
                    if (div_zero) begin
                        state_next = DIV_DONE;
                        res_we     = 1'b1;
                        res_q      = DIV_ZERO_QUOT;
                        res_r      = dividend;
                    end else if (early) begin
                        state_next = DIV_DONE;
                        res_we     = 1'b1;
                        res_q      = '0;
                        res_r      = dividend;
                    end else begin
                        state_next = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                div_stall = 1'b1;
                if (cnt == DIV_LAST_STEP) begin
                    state_next = DIV_DONE;
                    res_we     = 1'b1;
                    res_q      = div_cond_neg(quo_step, neg_q);
                    res_r      = div_cond_neg(rem_step, neg_r);
                end
            end
            DIV_DONE: begin
                done       = 1'b1;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase

        // A cancelled instruction must never reach the LO/HI result registers
        if (flush) begin
            state_next = DIV_IDLE;
            res_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            quo_sr    <= '0;
            rem_acc   <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                quo_sr  <= a_mag;
                rem_acc <= '0;
                dvsr    <= b_mag;
                neg_q   <= is_sign && (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
                neg_r   <= is_sign && dividend[DIV_WIDTH-1];
                cnt     <= '0;
            end else if (state == DIV_BUSY) begin
                quo_sr  <= quo_step;
                rem_acc <= rem_step;
                cnt     <= cnt + DIV_CNT_W'(1);
            end
            if (res_we) begin
                quotient  <= res_q;
                remainder <= res_r;
            end
        end
    end

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: the driver pushes expected results with
// their due cycle, a negedge monitor pops and compares on every done strobe.
module tb_exe_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        div_stall;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        int unsigned when;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

`ifdef DIV_EARLY_OUT_EN
    localparam int unsigned EO_LAT = 1;
`else
    localparam int unsigned EO_LAT = 33;
`endif

    exe_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_sign   (is_sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .div_stall (div_stall),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 q=%h r=%h expected no done (cycle %0d)",
                         quotient, remainder, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.when);
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
            end
        end
    end

    task automatic run_one(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int unsigned lat);
        exp_t        e;
        int unsigned stall_cnt;
        logic        got;
        @(posedge clk); #1;
        start    = 1'b1;
        is_sign  = sgn;
        dividend = a;
        divisor  = b;
        e.when   = cyc + lat;
        e.q      = eq;
        e.r      = er;
        sb.push_back(e);
        stall_cnt = 0;
        got       = 1'b0;
        @(negedge clk);
        if (div_stall) stall_cnt++;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        is_sign  = ~sgn;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (div_stall) stall_cnt++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 80 cycles expected done after %0d", lat);
        end
        check("stall_cycles", 32'(stall_cnt), 32'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int unsigned k;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        is_sign  = 1'b0;
        dividend = '0;
        divisor  = '0;
        flush    = 1'b0;

        // Reset state, and reset overriding a divide-by-zero start
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_quotient", quotient, 32'h0);
        check("rst_remainder", remainder, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_stall", {31'b0, div_stall}, 32'h0);

        // Directed vectors
        run_one(1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);
        run_one(1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33);
        run_one(1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         33);
        run_one(1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1);
        run_one(1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1);
        run_one(1'b0, 32'd3,         32'd9,         32'd0,         32'd3,         EO_LAT);
        run_one(1'b1, 32'hFFFFFFFD,  32'd9,         32'd0,         32'hFFFFFFFD,  EO_LAT);
        run_one(1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         33);
        run_one(1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         33);
        run_one(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         33);
        run_one(1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);

        // Flush at BUSY cycle 10: no done, results untouched
        @(posedge clk); #1;
        start = 1'b1; is_sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'b0, div_stall}, 32'h0);
        check("flush_done", {31'b0, done}, 32'h0);
        check("flush_quotient", quotient, 32'd14);
        check("flush_remainder", remainder, 32'd2);
        repeat (40) @(posedge clk);

        // Reset mid-BUSY: operation abandoned, results cleared
        #1;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_quotient", quotient, 32'h0);
        check("midrst_remainder", remainder, 32'h0);
        check("midrst_stall", {31'b0, div_stall}, 32'h0);
        repeat (40) @(posedge clk);

        // Back-to-back with start held across DONE
        #1;
        start = 1'b1; is_sign = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        k = cyc;
        e.when = k + 33; e.q = 32'd100; e.r = 32'd0;
        sb.push_back(e);
        e.when = k + 34 + 33; e.q = 32'hFFFFFFF2; e.r = 32'hFFFFFFFE;
        sb.push_back(e);
        @(posedge clk); #1;
        is_sign = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
        for (int i = 0; i < 60 && cyc < k + 35; i++) @(posedge clk);
        #1 start = 1'b0;

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_div_unit.md
EXE_DIV_UNIT -- requirements
Module: exe_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, EXE-stage instruction is a valid divide (driven from the ID/EXE is_div field).
REQ-004 SHALL have port is_sign, input, 1, 1 selects DIV, 0 selects DIVU (from the ID/EXE is_sign_div field).
REQ-005 SHALL have port dividend, input, 32, rs operand after forwarding.
REQ-006 SHALL have port divisor, input, 32, rt operand after forwarding.
REQ-007 SHALL have port flush, input, 1, exception/irq cancel of the EXE instruction.
REQ-008 SHALL have port div_stall, output, 1, pipeline stall request to IF/ID/EXE.
REQ-009 SHALL have port done, output, 1, one-cycle result-valid strobe.
REQ-010 SHALL have port quotient, output, 32, LO write data.
REQ-011 SHALL have port remainder, output, 32, HI write data.

Function
REQ-012 SHALL implement states IDLE, BUSY and DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL latch magnitudes, signs and is_sign, clear the iteration counter, and go to BUSY.
REQ-014 BUSY SHALL perform one restoring radix-2 shift-subtract step per cycle for exactly 32 cycles, then go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-016 Latency from the accept edge to done=1 SHALL be 33 cycles; back-to-back divides are accepted on the cycle after DONE.
REQ-017 div_stall SHALL be combinational: (IDLE and start and not flush) or BUSY; it SHALL be 0 in DONE.
REQ-018 Signed mode SHALL divide 32-bit magnitudes; quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-019 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0.
REQ-020 A divisor of 0 SHALL skip BUSY, going IDLE->DONE with quotient 0xFFFFFFFF and remainder = dividend (raw).
REQ-021 flush in any state SHALL force IDLE on the next edge with done=0; the result registers are left unchanged.
REQ-022 quotient and remainder SHALL hold their last values until the next DONE.
REQ-023 Operand changes after the accept edge SHALL have no effect.

Reset
REQ-024 rst SHALL force IDLE, done=0, quotient=0, remainder=0 and the counter to 0, taking priority over start and flush.
REQ-025 rst asserted mid-BUSY SHALL abandon the operation with no done pulse.

Configuration
REQ-026 With DIV_EARLY_OUT_EN defined, IDLE SHALL go directly to DONE when |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero), with quotient 0 and remainder = dividend (raw); latency is 1 cycle.
REQ-027 Without DIV_EARLY_OUT_EN, every nonzero-divisor operation SHALL take the full 33 cycles.

Structure
REQ-028 The state encoding, DIV_WIDTH=32 and the divide-by-zero result constants SHALL reside in the shared CPU package.
REQ-029 The block SHALL be a single module with no sub-modules; the iteration datapath is inline.

Verification
REQ-030 DIVU 100/7: start pulse, then done exactly 33 cycles later with quotient=14, remainder=2; div_stall high for 33 cycles.
REQ-031 DIV -7/2 (0xFFFFFFF9/2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-032 DIVU 5/0: done on the next cycle with quotient 0xFFFFFFFF, remainder 5.
REQ-033 flush at BUSY cycle 10: IDLE next cycle, no done, div_stall=0, and quotient/remainder keep their old values.
REQ-034 Two consecutive divides with start held high across the DONE cycle: the second is accepted the cycle after DONE and both results are correct.
REQ-035 With DIV_EARLY_OUT_EN, DIVU 3/9: done 1 cycle after accept, quotient 0, remainder 3; without the macro, 33 cycles with the same result.
